// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC controller bus: D/M-stage redirect requests and the
// instruction-memory handshake come in, while the fetch address and the
// pipeline valid/flush controls go out.
interface pc_sequencer_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        eret;
    logic [31:0] epc;
    logic        exc_req;
    logic        im_ready;
    logic [31:0] pc;
    logic        if_valid;
    logic        flush_fd;
    logic        flush_all;
    logic        pend;
    logic        pc_adel;

    // Pipeline side: it issues the requests and consumes the fetch controls.
    modport master (
        output stall, br_taken, br_target, eret, epc, exc_req, im_ready,
        input  pc, if_valid, flush_fd, flush_all, pend, pc_adel
    );

    // PC sequencer side.
    modport slave (
        input  stall, br_taken, br_target, eret, epc, exc_req, im_ready,
        output pc, if_valid, flush_fd, flush_all, pend, pc_adel
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller for the 5-stage MIPS pipeline.
// This block owns the PC register and picks the next fetch address from four
// sources: sequential PC+4, a D-stage branch/jump, an eret return to EPC, or
// exception entry. If a redirect arrives while an instruction-memory fetch is
// still outstanding, the block latches it as a pending redirect and applies it
// when the fetch completes. A pending redirect with the kill bit set, from an
// exception or an eret, marks the returning word as wrong-path.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input logic         clk,
    input logic         reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        pend_q;
    logic        kill_q;
    logic [31:0] target_q;

    logic [31:0] pc_next;
    logic        pend_next;
    logic        kill_next;
    logic [31:0] target_next;
    logic        fetch_ok;
    logic        take_branch;
    logic        kill_waiting;

    // A stalled branch is ignored, because D resolves it again next cycle.
    assign take_branch  = bus.br_taken && !bus.stall;
    // A kill pend must never be displaced by a later branch or eret.
    assign kill_waiting = pend_q && kill_q;

    // Next-PC selection and pending-redirect bookkeeping, in priority order.
    always_comb begin
        pc_next     = pc_q;
        pend_next   = pend_q;
        kill_next   = kill_q;
        target_next = target_q;
        fetch_ok    = 1'b0;
        if (bus.exc_req) begin
            if (bus.im_ready) begin
                pc_next   = EXC_PC;
                pend_next = 1'b0;
                kill_next = 1'b0;
            end else begin
                pend_next   = 1'b1;
                kill_next   = 1'b1;
                target_next = EXC_PC;
            end
        end else if (bus.eret || take_branch) begin
            if (kill_waiting) begin
                if (bus.im_ready) begin
                    pc_next   = target_q;
                    pend_next = 1'b0;
                    kill_next = 1'b0;
                end
            end else if (bus.im_ready) begin
                pc_next   = bus.eret ? bus.epc : bus.br_target;
                pend_next = 1'b0;
                kill_next = 1'b0;
                fetch_ok  = !bus.eret;
            end else begin
                pend_next   = 1'b1;
                kill_next   = bus.eret;
                target_next = bus.eret ? bus.epc : bus.br_target;
            end
        end else if (bus.im_ready) begin
            if (pend_q) begin
                if (kill_q) begin
                    pc_next   = target_q;
                    pend_next = 1'b0;
                    kill_next = 1'b0;
                end else if (!bus.stall) begin
                    pc_next   = target_q;
                    pend_next = 1'b0;
                    fetch_ok  = 1'b1;
                end
            end else if (!bus.stall) begin
                pc_next  = pc_q + 32'd4;
                fetch_ok = 1'b1;
            end
        end
    end

    // PC register, pending redirect and fetch FSM, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            pend_q   <= 1'b0;
            kill_q   <= 1'b0;
            target_q <= 32'h0;
        end else begin
            pc_q     <= pc_next;
            pend_q   <= pend_next;
            kill_q   <= kill_next;
            target_q <= target_next;
            unique case (state)
                RUN:  if (!bus.im_ready) state <= WAIT;
                WAIT: if (bus.im_ready)  state <= RUN;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pend      = pend_q;
    assign bus.pc_adel   = (pc_q[1:0] != 2'b00);
    assign bus.if_valid  = !reset && fetch_ok;
    assign bus.flush_all = !reset && bus.exc_req;
    assign bus.flush_fd  = !reset && !bus.exc_req && bus.eret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random traffic,
// with a queue-based scoreboard fed by a behavioural model of the fetch PC.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    typedef struct {
        logic        known;
        logic [31:0] pc;
        logic        pend;
        logic        adel;
        logic        ifv;
        logic        ffd;
        logic        fall;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    // Model state: the architectural PC plus an optional deferred redirect.
    logic        m_known;
    logic [31:0] m_pc;
    logic        m_pend;
    logic        m_kill;
    logic [31:0] m_tgt;

    pc_sequencer_if sif ();

    pc_sequencer #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Predict this cycle's outputs and advance the model by one edge.
    task automatic model_cycle(input logic r, input logic st, input logic br, input logic [31:0] bt,
                               input logic er, input logic [31:0] ep, input logic ex, input logic im);
        exp_t e;
        int   kind;
        logic kill_pending;
        e.known = m_known;
        e.pc    = m_pc;
        e.pend  = m_pend;
        e.adel  = (m_pc % 4) != 0;
        e.ifv   = 1'b0;
        e.ffd   = 1'b0;
        e.fall  = 1'b0;
        // 0 none, 1 exception, 2 eret, 3 branch (stalled branches do not count)
        kind = ex ? 1 : er ? 2 : (br && !st) ? 3 : 0;
        kill_pending = m_pend && m_kill;
        if (r) begin
            m_known = 1'b1;
            m_pc    = RESET_PC;
            m_pend  = 1'b0;
            m_kill  = 1'b0;
            m_tgt   = 32'h0;
        end else begin
            e.fall = (kind == 1);
            e.ffd  = (kind == 2);
            if (kind == 1) begin
                if (im) begin m_pc = EXC_PC; m_pend = 1'b0; m_kill = 1'b0; end
                else begin m_pend = 1'b1; m_kill = 1'b1; m_tgt = EXC_PC; end
            end else if (kind != 0 && !im) begin
                if (!kill_pending) begin
                    m_pend = 1'b1;
                    m_kill = (kind == 2);
                    m_tgt  = (kind == 2) ? ep : bt;
                end
            end else if (im && kill_pending) begin
                m_pc = m_tgt; m_pend = 1'b0; m_kill = 1'b0;
            end else if (im && kind == 2) begin
                m_pc = ep; m_pend = 1'b0; m_kill = 1'b0;
            end else if (im && kind == 3) begin
                m_pc = bt; m_pend = 1'b0; m_kill = 1'b0; e.ifv = 1'b1;
            end else if (im && !st) begin
                m_pc   = m_pend ? m_tgt : m_pc + 32'd4;
                m_pend = 1'b0;
                e.ifv  = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic r, input logic st, input logic br, input logic [31:0] bt,
                                  input logic er, input logic [31:0] ep, input logic ex, input logic im);
        @(posedge clk);
        #1;
        reset         = r;
        sif.stall     = st;
        sif.br_taken  = br;
        sif.br_target = bt;
        sif.eret      = er;
        sif.epc       = ep;
        sif.exc_req   = ex;
        sif.im_ready  = im;
        model_cycle(r, st, br, bt, er, ep, ex, im);
    endtask

    task automatic check_output(input exp_t e);
        if (e.known) begin
            check_field("pc", sif.pc, e.pc);
            check_field("pend", {31'h0, sif.pend}, {31'h0, e.pend});
            check_field("pc_adel", {31'h0, sif.pc_adel}, {31'h0, e.adel});
        end
        check_field("if_valid", {31'h0, sif.if_valid}, {31'h0, e.ifv});
        check_field("flush_fd", {31'h0, sif.flush_fd}, {31'h0, e.ffd});
        check_field("flush_all", {31'h0, sif.flush_all}, {31'h0, e.fall});
    endtask

    // Monitor: the DUT presents a fresh set of outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        logic [31:0] bt;
        logic [31:0] ep;
        checks   = 0;
        failures = 0;
        m_known  = 1'b0;
        m_pc     = 32'h0;
        m_pend   = 1'b0;
        m_kill   = 1'b0;
        m_tgt    = 32'h0;
        reset         = 1'b1;
        sif.stall     = 1'b0;
        sif.br_taken  = 1'b0;
        sif.br_target = 32'h0;
        sif.eret      = 1'b0;
        sif.epc       = 32'h0;
        sif.exc_req   = 1'b0;
        sif.im_ready  = 1'b1;

        // Reset, then sequential fetch 3000..3010
        repeat (2) apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // Stalled branch at 3010 is ignored, the unstalled one redirects to 3100
        apply_stimulus(0, 1, 1, 32'h3100, 0, 0, 0, 1);
        apply_stimulus(0, 0, 1, 32'h3100, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // Branch during a wait is latched and applied on completion
        apply_stimulus(0, 0, 1, 32'h3200, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // Branch, exception, then branch during a wait: the exception pend wins
        apply_stimulus(0, 0, 1, 32'h3200, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 1, 32'h3300, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // eret ignores stall; eret together with an exception takes the exception
        apply_stimulus(0, 1, 0, 0, 1, 32'h3044, 0, 1);
        apply_stimulus(0, 0, 0, 0, 1, 32'h3044, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // Misaligned branch target raises pc_adel
        apply_stimulus(0, 0, 1, 32'h3102, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // Reset while a redirect is pending discards it
        apply_stimulus(0, 0, 1, 32'h3200, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bt = {$urandom_range(32'h0000_3fff, 32'h0000_3000)} & 32'hffff_fffc;
            ep = {$urandom_range(32'h0000_3fff, 32'h0000_3000)} & 32'hffff_fffc;
            if ($urandom_range(15, 0) == 0) bt[1:0] = 2'($urandom_range(3, 1));
            if ($urandom_range(15, 0) == 0) ep[1:0] = 2'($urandom_range(3, 1));
            if (i % 500 == 400) bt = 32'hffff_fff8;
            apply_stimulus($urandom_range(49, 0) == 0,
                           $urandom_range(4, 0) == 0,
                           $urandom_range(4, 0) == 0, bt,
                           $urandom_range(19, 0) == 0, ep,
                           $urandom_range(19, 0) == 0,
                           $urandom_range(9, 0) < 7);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);

        // Let the monitor drain, bounded to a few cycles
        repeat (4) @(negedge clk);
        check_field("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
